// File: rtl/dual_image_pixel_divider_pipe_pkg.sv
// Shared widths, latency helpers and alignment-FSM encoding for the dual-image pixel divider.
package img_arith_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_FRAC_BITS = 8;
  localparam int unsigned DIV_Q         = DEF_DATA_W + DEF_FRAC_BITS;
  localparam int unsigned DIV_L         = DIV_Q + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LINE = 2'd1,
    ST_ERR  = 2'd2
  } align_state_t;

  function automatic int unsigned quo_width(input int unsigned data_w, input int unsigned frac_bits);
    return data_w + frac_bits;
  endfunction

  function automatic int unsigned pipe_latency(input int unsigned data_w, input int unsigned frac_bits);
    return quo_width(data_w, frac_bits) + 2;
  endfunction

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dual_image_pixel_divider_pipe_if.sv
// Master/slave pixel stream inputs plus divider results; o_div_zero only exists with DIV_ZERO_FLAG_EN.
interface dual_image_pixel_divider_pipe_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 32
);
  logic         i_h_sync_m;
  logic         i_v_sync_m;
  logic [N-1:0] i_data_m;
  logic         i_h_sync_s;
  logic         i_v_sync_s;
  logic [N-1:0] i_data_s;
  logic         o_v_sync;
  logic         o_h_sync;
  logic [W-1:0] o_res_data;
  logic         o_align_err;
`ifdef DIV_ZERO_FLAG_EN
  logic         o_div_zero;
`endif

  modport master (
    output i_h_sync_m, i_v_sync_m, i_data_m, i_h_sync_s, i_v_sync_s, i_data_s,
`ifdef DIV_ZERO_FLAG_EN
    input  o_div_zero,
`endif
    input  o_v_sync, o_h_sync, o_res_data, o_align_err
  );

  modport slave (
    input  i_h_sync_m, i_v_sync_m, i_data_m, i_h_sync_s, i_v_sync_s, i_data_s,
`ifdef DIV_ZERO_FLAG_EN
    output o_div_zero,
`endif
    output o_v_sync, o_h_sync, o_res_data, o_align_err
  );

endinterface

// File: rtl/dual_image_pixel_divider_pipe_div_restoring_stage.sv
// One restoring-division step: shifts in the next dividend bit, resolves one quotient bit, registers it.
// Dividend and quotient share one register: dividend MSBs shift out as quotient LSBs shift in.
module div_restoring_stage
  import img_arith_pkg::*;
#(
  parameter int unsigned N = DEF_DATA_W,
  parameter int unsigned Q = DIV_Q
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic         vs,
  input  logic         zero,
  input  logic [N-1:0] rem,
  input  logic [Q-1:0] dq,
  input  logic [N-1:0] dvs,
  output logic         vld_q,
  output logic         vs_q,
  output logic         zero_q,
  output logic [N-1:0] rem_q,
  output logic [Q-1:0] dq_q,
  output logic [N-1:0] dvs_q
);

  logic [N:0]   trial;
  logic         fits;
  logic [N-1:0] diff;

  assign trial = {rem, dq[Q-1]};
  assign fits  = (trial >= {1'b0, dvs});
  // Only used when fits, so the result is below dvs and fits in N bits.
  assign diff  = trial[N-1:0] - dvs;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      vs_q   <= 1'b0;
      zero_q <= 1'b0;
      rem_q  <= '0;
      dq_q   <= '0;
      dvs_q  <= '0;
    end else begin
      vld_q  <= vld;
      vs_q   <= vs;
      zero_q <= zero;
      rem_q  <= fits ? diff : trial[N-1:0];
      dq_q   <= (dq << 1) | Q'(fits);
      dvs_q  <= dvs;
    end
  end

endmodule

// File: rtl/dual_image_pixel_divider_pipe.sv
// Pixel-wise unsigned Q.F division master/slave, L = N+F+2 cycles, 1 pixel/clk, plus line alignment check.
// Build option DIV_ZERO_FLAG_EN adds o_div_zero.
module dual_image_pixel_divider_pipe
  import img_arith_pkg::*;
#(
  parameter int unsigned P_INPUT_DATA_WIDTH  = DEF_DATA_W,
  parameter int unsigned P_FRAC_BITS         = DEF_FRAC_BITS,
  parameter int unsigned P_OUTPUT_DATA_WIDTH = 32,
  parameter int unsigned P_IMG_WIDTH         = 256
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  dual_image_pixel_divider_pipe_if.slave bus
);

  localparam int unsigned N     = P_INPUT_DATA_WIDTH;
  localparam int unsigned F     = P_FRAC_BITS;
  localparam int unsigned Q     = quo_width(N, F);
  localparam int unsigned W     = P_OUTPUT_DATA_WIDTH;
  localparam int unsigned CNT_W = clog2(P_IMG_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(P_IMG_WIDTH);

  logic         h_m_r, h_s_r, v_m_r, v_s_r;
  logic [N-1:0] data_m_r, data_s_r;
  logic         v0, vld0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_m_r    <= 1'b0;
      h_s_r    <= 1'b0;
      v_m_r    <= 1'b0;
      v_s_r    <= 1'b0;
      data_m_r <= '0;
      data_s_r <= '0;
    end else begin
      h_m_r    <= bus.i_h_sync_m;
      h_s_r    <= bus.i_h_sync_s;
      v_m_r    <= bus.i_v_sync_m;
      v_s_r    <= bus.i_v_sync_s;
      data_m_r <= bus.i_data_m;
      data_s_r <= bus.i_data_s;
    end
  end

  assign v0   = v_m_r & v_s_r;
  assign vld0 = h_m_r & h_s_r & v0;

  logic         pipe_vld  [0:Q];
  logic         pipe_vs   [0:Q];
  logic         pipe_zero [0:Q];
  logic [N-1:0] pipe_rem  [0:Q];
  logic [Q-1:0] pipe_dq   [0:Q];
  logic [N-1:0] pipe_dvs  [0:Q];

  assign pipe_vld[0] = vld0;
  assign pipe_vs[0]  = v0;
  assign pipe_rem[0] = '0;
  assign pipe_dq[0]  = Q'(data_m_r) << F;
  assign pipe_dvs[0] = data_s_r;
`ifdef DIV_ZERO_FLAG_EN
  assign pipe_zero[0] = (data_s_r == '0);
`else
  // Without the flag, a zero divisor already makes every restoring step succeed: all-ones quotient.
  assign pipe_zero[0] = 1'b0;
`endif

  for (genvar i = 0; i < Q; i++) begin : g_stage
    div_restoring_stage #(.N(N), .Q(Q)) u_stage (
      .clk    (i_clk),
      .rst    (i_rst),
      .vld    (pipe_vld[i]),
      .vs     (pipe_vs[i]),
      .zero   (pipe_zero[i]),
      .rem    (pipe_rem[i]),
      .dq     (pipe_dq[i]),
      .dvs    (pipe_dvs[i]),
      .vld_q  (pipe_vld[i+1]),
      .vs_q   (pipe_vs[i+1]),
      .zero_q (pipe_zero[i+1]),
      .rem_q  (pipe_rem[i+1]),
      .dq_q   (pipe_dq[i+1]),
      .dvs_q  (pipe_dvs[i+1])
    );
  end

  logic [Q-1:0] quo_fin;
  logic [W-1:0] res_fin;

  assign quo_fin = pipe_zero[Q] ? '1 : pipe_dq[Q];

  if (Q > W) begin : g_sat
    assign res_fin = (|quo_fin[Q-1:W]) ? '1 : quo_fin[W-1:0];
  end else begin : g_ext
    assign res_fin = W'(quo_fin);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_v_sync   <= 1'b0;
      bus.o_h_sync   <= 1'b0;
      bus.o_res_data <= '0;
`ifdef DIV_ZERO_FLAG_EN
      bus.o_div_zero <= 1'b0;
`endif
    end else begin
      bus.o_v_sync   <= pipe_vs[Q];
      bus.o_h_sync   <= pipe_vld[Q];
      bus.o_res_data <= pipe_vld[Q] ? res_fin : '0;
`ifdef DIV_ZERO_FLAG_EN
      bus.o_div_zero <= pipe_vld[Q] & pipe_zero[Q];
`endif
    end
  end

  // Alignment check runs on the raw inputs; stage-0 v is the previous-cycle v for edge detection.
  logic v_now, vld_now, v_rise, h_mismatch;
  assign v_now      = bus.i_v_sync_m & bus.i_v_sync_s;
  assign vld_now    = bus.i_h_sync_m & bus.i_h_sync_s & v_now;
  assign v_rise     = v_now & ~v0;
  assign h_mismatch = v_now & (bus.i_h_sync_m ^ bus.i_h_sync_s);

  align_state_t     state, st_base, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_base, cnt_nxt;
  logic             align_err;

  always_comb begin
    st_base  = v_rise ? ST_IDLE : state;
    cnt_base = v_rise ? '0 : cnt;
    st_nxt   = st_base;
    cnt_nxt  = cnt_base;
    case (st_base)
      ST_IDLE: begin
        if (vld_now) begin
          st_nxt  = ST_LINE;
          cnt_nxt = CNT_W'(1);
        end
      end
      ST_LINE: begin
        if (vld_now) begin
          if (cnt_base != '1) cnt_nxt = cnt_base + 1'b1;
        end else begin
          st_nxt = (cnt_base == CNT_TARGET) ? ST_IDLE : ST_ERR;
        end
      end
      ST_ERR:  st_nxt = ST_ERR;
      default: st_nxt = ST_IDLE;
    endcase
    // A mismatch on the rising-edge cycle lands after the clear, so the frame starts in error.
    if (h_mismatch) st_nxt = ST_ERR;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      align_err <= 1'b0;
    end else begin
      state     <= st_nxt;
      cnt       <= cnt_nxt;
      align_err <= (st_nxt == ST_ERR);
    end
  end

  assign bus.o_align_err = align_err;

endmodule

// File: tb/tb_dual_image_pixel_divider_pipe.sv
// Directed bench for dual_image_pixel_divider_pipe: delayed-result model per cycle plus alignment/reset checks.
module tb_dual_image_pixel_divider_pipe;
  import img_arith_pkg::*;

  localparam int LAT = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dual_image_pixel_divider_pipe_if #(.N(8), .W(32)) bus ();

  dual_image_pixel_divider_pipe #(
    .P_INPUT_DATA_WIDTH  (8),
    .P_FRAC_BITS         (8),
    .P_OUTPUT_DATA_WIDTH (32),
    .P_IMG_WIDTH         (256)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int h_cnt    = 0;
  logic [34:0] hist [LAT];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Compares outputs with the word pushed LAT steps ago, then applies new inputs for one cycle.
  task automatic step(input logic r, input logic hm, input logic hs, input logic v,
                      input logic [7:0] dm, input logic [7:0] ds, input logic [31:0] res);
    logic [34:0] obs;
    logic        valid, dz_o, dz_e;
`ifdef DIV_ZERO_FLAG_EN
    dz_o = bus.o_div_zero;
`else
    dz_o = 1'b0;
`endif
    obs = {bus.o_v_sync, bus.o_h_sync, dz_o, bus.o_res_data};
    check($sformatf("pipe@%0d", cyc), 64'(obs), 64'(hist[LAT-1]));
    if (bus.o_h_sync === 1'b1) h_cnt++;
    for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
    valid = hm & hs & v;
`ifdef DIV_ZERO_FLAG_EN
    dz_e = valid & (ds == 8'd0);
`else
    dz_e = 1'b0;
`endif
    if (r) begin
      for (int i = 0; i < LAT; i++) hist[i] = '0;
    end else begin
      hist[0] = {v, valid, dz_e, (valid ? res : 32'd0)};
    end
    rst            = r;
    bus.i_h_sync_m = hm;
    bus.i_h_sync_s = hs;
    bus.i_v_sync_m = v;
    bus.i_v_sync_s = v;
    bus.i_data_m   = dm;
    bus.i_data_s   = ds;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, v, 8'd0, 8'd0, 32'd0);
  endtask

  logic [7:0]  vec_m   [8] = '{8'd200, 8'd1, 8'd255, 8'd7, 8'd255, 8'd0, 8'd1, 8'd255};
  logic [7:0]  vec_s   [8] = '{8'd4, 8'd3, 8'd255, 8'd0, 8'd1, 8'd9, 8'd255, 8'd0};
  logic [31:0] vec_res [8] = '{32'h3200, 32'h55, 32'h100, 32'hFFFF, 32'hFF00, 32'h0, 32'h1, 32'hFFFF};

  initial begin
    logic [7:0]  m, s;
    logic [31:0] e;
    for (int i = 0; i < LAT; i++) hist[i] = '0;
    rst = 1'b1;
    bus.i_h_sync_m = 1'b0; bus.i_h_sync_s = 1'b0;
    bus.i_v_sync_m = 1'b0; bus.i_v_sync_s = 1'b0;
    bus.i_data_m   = 8'd0; bus.i_data_s   = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_vsync", 64'(bus.o_v_sync), 64'd0);
    check("rst_hsync", 64'(bus.o_h_sync), 64'd0);
    check("rst_data",  64'(bus.o_res_data), 64'd0);
    check("rst_err",   64'(bus.o_align_err), 64'd0);

    // Single-pixel line with explicit latency checks, then the rest of the table back to back.
    idle(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, vec_m[0], vec_s[0], vec_res[0]);
    idle(LAT - 2, 1'b1);
    check("t1_early_hsync", 64'(bus.o_h_sync), 64'd0);
    idle(1, 1'b1);
    check("t1_hsync", 64'(bus.o_h_sync), 64'd1);
    check("t1_data",  64'(bus.o_res_data), 64'h3200);
    for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b1, vec_m[i], vec_s[i], vec_res[i]);
    idle(LAT + 2, 1'b1);

    // Full 256-pixel line with random data.
    idle(2, 1'b0);
    idle(2, 1'b1);
    h_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      m = 8'($urandom_range(0, 255));
      s = 8'($urandom_range(0, 255));
      e = (s == 8'd0) ? 32'hFFFF : ((32'(m) << 8) / 32'(s));
      step(1'b0, 1'b1, 1'b1, 1'b1, m, s, e);
      if (i == 128) check("line256_mid_err", 64'(bus.o_align_err), 64'd0);
    end
    idle(LAT + 2, 1'b1);
    check("line256_err",  64'(bus.o_align_err), 64'd0);
    check("line256_hcnt", 64'(h_cnt), 64'd256);

    // Slave line lags master by one cycle.
    idle(2, 1'b0);
    idle(2, 1'b1);
    check("lag_pre_err", 64'(bus.o_align_err), 64'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd100, 8'd10, 32'd0);
    check("lag_err", 64'(bus.o_align_err), 64'd1);
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b1, 8'd100, 8'd10, 32'hA00);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'd100, 8'd10, 32'd0);
    idle(3, 1'b1);
    check("lag_hold", 64'(bus.o_align_err), 64'd1);
    idle(1, 1'b0);
    check("lag_hold_vlow", 64'(bus.o_align_err), 64'd1);
    idle(1, 1'b1);
    check("lag_clear", 64'(bus.o_align_err), 64'd0);

    // Rising edge of v coinciding with a mismatch ends in error.
    idle(1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 32'd0);
    check("rise_mismatch_err", 64'(bus.o_align_err), 64'd1);
    idle(1, 1'b0);
    idle(2, 1'b1);
    check("rise_mismatch_clear", 64'(bus.o_align_err), 64'd0);

    // 255-pixel line: short by one.
    repeat (255) step(1'b0, 1'b1, 1'b1, 1'b1, 8'd50, 8'd5, 32'hA00);
    check("line255_in_line", 64'(bus.o_align_err), 64'd0);
    idle(1, 1'b1);
    check("line255_err", 64'(bus.o_align_err), 64'd1);
    idle(LAT + 2, 1'b1);
    idle(1, 1'b0);
    idle(1, 1'b1);
    check("line255_clear", 64'(bus.o_align_err), 64'd0);

    // Reset pulse mid-line with error set and pixels in flight.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd20, 8'd3, 32'd0);
    repeat (10) step(1'b0, 1'b1, 1'b1, 1'b1, 8'd20, 8'd3, 32'h6AA);
    check("pre_rst_err", 64'(bus.o_align_err), 64'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'd20, 8'd3, 32'h6AA);
    check("mid_rst_vsync", 64'(bus.o_v_sync), 64'd0);
    check("mid_rst_hsync", 64'(bus.o_h_sync), 64'd0);
    check("mid_rst_data",  64'(bus.o_res_data), 64'd0);
    check("mid_rst_err",   64'(bus.o_align_err), 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("mid_rst_dz",    64'(bus.o_div_zero), 64'd0);
`endif
    h_cnt = 0;
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b1, 8'd20, 8'd3, 32'h6AA);
    idle(LAT + 2, 1'b1);
    check("post_rst_hcnt", 64'(h_cnt), 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
